// File: rtl/result_streamer.sv
// Streams a 4-byte size header plus the downscaled image bytes read from memory.
// Define RESULT_STREAMER_COUNTERS_EN to append six performance-counter bytes.
module result_streamer #(
    parameter logic [15:0] OUT_BASE = 16'h4000,
    parameter logic [15:0] CNT_BASE = 16'hFFF8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    output logic        busy,
    output logic        done,
    output logic        mem_re,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready
);

`ifdef RESULT_STREAMER_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
    typedef enum logic [3:0] {
        IDLE, HDR, RD_REQ, RD_WAIT, PIX_OUT,
        CNT_REQ, CNT_WAIT, CNT_OUT, FIN
    } state_t;
    logic [2:0] cnt_idx_q;
`else
    localparam bit CNT_EN = 1'b0;
    typedef enum logic [3:0] {
        IDLE, HDR, RD_REQ, RD_WAIT, PIX_OUT, FIN
    } state_t;
`endif

    state_t      state_q;
    logic [15:0] out_w_q, out_h_q, npix_q, pix_idx_q;
    logic [1:0]  hdr_idx_q;

    logic [15:0] w_in_d, h_in_d, npix_in_d;
    logic [7:0]  hdr_nxt_d;
    logic        pix_last_d;
    logic        unused_bits;

    assign w_in_d     = {1'b0, cfg_width[15:1]};
    assign h_in_d     = {1'b0, cfg_height[15:1]};
    assign npix_in_d  = w_in_d * h_in_d;
    assign pix_last_d = (pix_idx_q == npix_q - 16'd1);

`ifdef RESULT_STREAMER_COUNTERS_EN
    assign unused_bits = cfg_width[0] ^ cfg_height[0];
`else
    assign unused_bits = ^{cfg_width[0], cfg_height[0], CNT_BASE};
`endif

    // Header byte that follows the one currently presented.
    always_comb begin
        hdr_nxt_d = out_w_q[7:0];
        case (hdr_idx_q)
            2'd0:    hdr_nxt_d = out_w_q[15:8];
            2'd1:    hdr_nxt_d = out_h_q[7:0];
            2'd2:    hdr_nxt_d = out_h_q[15:8];
            default: hdr_nxt_d = out_w_q[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= 16'd0;
            m_data    <= 8'd0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            out_w_q   <= 16'd0;
            out_h_q   <= 16'd0;
            npix_q    <= 16'd0;
            pix_idx_q <= 16'd0;
            hdr_idx_q <= 2'd0;
`ifdef RESULT_STREAMER_COUNTERS_EN
            cnt_idx_q <= 3'd0;
`endif
        end else begin
            mem_re <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    state_q   <= HDR;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    out_w_q   <= w_in_d;
                    out_h_q   <= h_in_d;
                    npix_q    <= npix_in_d;
                    pix_idx_q <= 16'd0;
                    hdr_idx_q <= 2'd0;
`ifdef RESULT_STREAMER_COUNTERS_EN
                    cnt_idx_q <= 3'd0;
`endif
                    m_data    <= w_in_d[7:0];
                    m_valid   <= 1'b1;
                    m_last    <= 1'b0;
                end
                HDR: if (m_ready) begin
                    if (hdr_idx_q == 2'd3) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (npix_q != 16'd0) begin
                            state_q  <= RD_REQ;
                            mem_re   <= 1'b1;
                            mem_addr <= OUT_BASE;
                        end else begin
`ifdef RESULT_STREAMER_COUNTERS_EN
                            state_q  <= CNT_REQ;
                            mem_re   <= 1'b1;
                            mem_addr <= CNT_BASE;
`else
                            state_q  <= FIN;
`endif
                        end
                    end else begin
                        hdr_idx_q <= hdr_idx_q + 2'd1;
                        m_data    <= hdr_nxt_d;
                        m_last    <= (hdr_idx_q == 2'd2) &&
                                     (npix_q == 16'd0) && !CNT_EN;
                    end
                end
                RD_REQ: state_q <= RD_WAIT;
                RD_WAIT: begin
                    state_q <= PIX_OUT;
                    m_data  <= mem_data_in;
                    m_valid <= 1'b1;
                    m_last  <= pix_last_d && !CNT_EN;
                end
                PIX_OUT: if (m_ready) begin
                    m_valid   <= 1'b0;
                    m_last    <= 1'b0;
                    pix_idx_q <= pix_idx_q + 16'd1;
                    if (!pix_last_d) begin
                        state_q  <= RD_REQ;
                        mem_re   <= 1'b1;
                        mem_addr <= OUT_BASE + pix_idx_q + 16'd1;
                    end else begin
`ifdef RESULT_STREAMER_COUNTERS_EN
                        state_q  <= CNT_REQ;
                        mem_re   <= 1'b1;
                        mem_addr <= CNT_BASE;
`else
                        state_q  <= FIN;
`endif
                    end
                end
`ifdef RESULT_STREAMER_COUNTERS_EN
                CNT_REQ: state_q <= CNT_WAIT;
                CNT_WAIT: begin
                    state_q <= CNT_OUT;
                    m_data  <= mem_data_in;
                    m_valid <= 1'b1;
                    m_last  <= (cnt_idx_q == 3'd5);
                end
                CNT_OUT: if (m_ready) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    if (cnt_idx_q == 3'd5) begin
                        state_q <= FIN;
                    end else begin
                        state_q   <= CNT_REQ;
                        cnt_idx_q <= cnt_idx_q + 3'd1;
                        mem_re    <= 1'b1;
                        mem_addr  <= CNT_BASE + {13'd0, cnt_idx_q} + 16'd1;
                    end
                end
`endif
                FIN: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
